alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: multiplier iteration count (operand width).
REQ-002 SHALL provide parameter NOP_CODE, default 6'b111110: alu_sel value when no operation is in flight.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 op_valid  input  1  requester presents an operation.
REQ-007 op_funct  input  6  function code: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SLL 0, MULTU 25.
REQ-008 abort  input  1  synchronous flush of any in-flight operation.
REQ-009 op_ready  output  1  sequencer can accept an operation this cycle.
REQ-010 alu_sel  output  6  select code driven to ALU, shifter, multiplier and result mux.
REQ-011 mul_start  output  1  one-cycle pulse that initialises the multiplier.
REQ-012 mul_step  output  1  multiplier iteration enable.
REQ-013 mul_count  output  6  current multiplier iteration index.
REQ-014 hilo_we  output  1  HiLo register write enable.
REQ-015 res_valid  output  1  one-cycle result-ready pulse.
REQ-016 illegal  output  1  one-cycle pulse for an unsupported op_funct.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, EXEC, MUL and HILO, all registered.
REQ-019 op_ready SHALL be 1 only in IDLE with abort=0.
REQ-020 An operation SHALL be accepted on a rising edge with op_valid=1 and op_ready=1; op_funct is latched at that edge.
REQ-021 In IDLE: alu_sel=NOP_CODE; mul_start, mul_step, hilo_we and res_valid are 0.
REQ-022 Accepted AND, OR, ADD, SUB, SLT or SLL SHALL go IDLE->EXEC for exactly one cycle.
REQ-023 During EXEC: alu_sel=latched funct and res_valid=1; the next state is IDLE (latency 1, throughput 1 op per 2 cycles).
REQ-024 Accepted MULTU SHALL go IDLE->MUL with mul_count cleared to 0.
REQ-025 In MUL, every cycle: alu_sel=6'b011001 and mul_step=1; mul_start=1 only while mul_count=0.
REQ-026 mul_count SHALL increment by 1 each MUL cycle; in the cycle where mul_count=WIDTH-1, the next state is HILO and mul_count returns to 0.
REQ-027 HILO SHALL last one cycle with alu_sel=6'b111111, hilo_we=1 and res_valid=1, then go to IDLE.
REQ-028 MULTU SHALL give exactly WIDTH MUL cycles; hilo_we rises WIDTH+1 cycles after the accept edge.
REQ-029 An accepted unsupported funct SHALL pulse illegal=1 for the next cycle, stay in IDLE, and produce no res_valid or hilo_we.
REQ-030 abort=1 SHALL move any state to IDLE at the next edge and clear mul_count; the cycle after it shows no res_valid or hilo_we.
REQ-031 abort=1 in the same cycle as op_valid=1 SHALL win: no accept, because op_ready=0.
REQ-032 abort=1 in the HILO cycle SHALL NOT suppress that cycle's hilo_we; the write completes.
REQ-033 op_funct changes while busy SHALL have no effect; only the latched funct is used.
REQ-034 mul_count SHALL be $clog2(WIDTH) bits zero-extended to 6, and SHALL wrap only via the REQ-026 clear.
REQ-035 illegal SHALL be a registered output.
REQ-036 All other outputs SHALL be decoded from state, the latched funct and mul_count.

Reset
REQ-037 rst_n=0 SHALL immediately force: state IDLE, mul_count 0, latched funct 0, illegal 0.
REQ-038 During reset, outputs SHALL be: op_ready=1, alu_sel=NOP_CODE, all other outputs 0.
REQ-039 Reset asserted mid-MUL or mid-HILO SHALL drop hilo_we and res_valid with no clock edge needed.

Verification
REQ-040 ADD (32) accepted at edge 0 -> cycle 1: alu_sel=32, res_valid=1, op_ready=0; cycle 2: IDLE, op_ready=1.
REQ-041 MULTU (25), WIDTH=32, accepted at edge 0 -> mul_start only in cycle 1; mul_step in cycles 1-32 with mul_count 0..31; cycle 33: alu_sel=63, hilo_we=1, res_valid=1.
REQ-042 funct 6'b000111 accepted -> illegal=1 for one cycle, busy=0, no res_valid.
REQ-043 abort at MUL with mul_count=10 -> next cycle: IDLE, mul_count=0; no hilo_we ever; a new ADD is accepted normally.
REQ-044 rst_n low mid-MULTU at mul_count=20 -> outputs at reset values with no clock edge; after release, a MULTU completes in a full 32 MUL cycles.
REQ-045 op_valid held high with alternating SUB and SLL -> each accepted every 2 cycles; res_valid alternates 1,0 with alu_sel 34 then 0.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Operation request channel between a requester and the ALU op sequencer.
// The requester holds op_valid/op_funct; the sequencer answers with op_ready.
interface alu_op_sequencer_if;
  logic       op_valid;
  logic [5:0] op_funct;
  logic       op_ready;

  modport master (
    output op_valid,
    output op_funct,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  op_funct,
    output op_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: turns one accepted funct into ALU/shifter/multiplier/HiLo controls.
// Latency 1 cycle (ALU ops) or WIDTH+1 cycles (MULTU); op_ready holds the requester off until IDLE.
module alu_op_sequencer #(
  parameter int         WIDTH    = 32,
  parameter logic [5:0] NOP_CODE = 6'b111110
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                abort,
  alu_op_sequencer_if.slave   op,
  output logic [5:0]          alu_sel,
  output logic                mul_start,
  output logic                mul_step,
  output logic [5:0]          mul_count,
  output logic                hilo_we,
  output logic                res_valid,
  output logic                illegal,
  output logic                busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] HILO = 2'd3;

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] SEL_HILO = 6'b111111;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [5:0]    funct_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          illegal_q;
  logic          accept;
  logic          is_alu;
  logic          is_mul;

  assign op.op_ready = (state == IDLE) && !abort;
  assign accept      = op.op_valid && op.op_ready;

  always_comb begin
    is_alu = 1'b0;
    is_mul = 1'b0;
    case (op.op_funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL: is_alu = 1'b1;
      F_MULTU:                                 is_mul = 1'b1;
      default: ;
    endcase
  end

  // abort overrides every transition; an accept can never coincide with it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_alu) begin
            state_nxt = EXEC;
          end else if (accept && is_mul) begin
            state_nxt = MUL;
            cnt_nxt   = '0;
          end
        end
        EXEC: state_nxt = IDLE;
        MUL: begin
          if (cnt == CNT_LAST) begin
            state_nxt = HILO;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        HILO:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      funct_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      illegal_q <= accept && !is_alu && !is_mul;
      if (accept) begin
        funct_q <= op.op_funct;
      end
    end
  end

  // Decoded outputs follow state, so an async reset drops them without an edge.
  always_comb begin
    alu_sel   = NOP_CODE;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    hilo_we   = 1'b0;
    res_valid = 1'b0;
    case (state)
      EXEC: begin
        alu_sel   = funct_q;
        res_valid = 1'b1;
      end
      MUL: begin
        alu_sel   = F_MULTU;
        mul_step  = 1'b1;
        mul_start = (cnt == '0);
      end
      HILO: begin
        alu_sel   = SEL_HILO;
        hilo_we   = 1'b1;
        res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    mul_count         = '0;
    mul_count[CW-1:0] = cnt;
  end

  assign illegal = illegal_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised and directed bench for alu_op_sequencer against a per-cycle expectation queue.
module tb_alu_op_sequencer;
  localparam int         WIDTH = 32;
  localparam logic [5:0] NOP   = 6'b111110;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] alu_sel;
  logic [5:0] mul_count;
  logic       mul_start, mul_step, hilo_we, res_valid, illegal, busy;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer_if op_bus();

  alu_op_sequencer #(.WIDTH(WIDTH), .NOP_CODE(NOP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .op        (op_bus),
    .alu_sel   (alu_sel),
    .mul_start (mul_start),
    .mul_step  (mul_step),
    .mul_count (mul_count),
    .hilo_we   (hilo_we),
    .res_valid (res_valid),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic [5:0] sel;
    logic       start;
    logic       step;
    logic [5:0] cnt;
    logic       hilo;
    logic       rv;
    logic       ill;
  } exp_t;

  typedef struct packed {
    logic rdy;
    exp_t e;
  } obs_t;

  // Reference model: each accepted op expands into the list of cycles it will occupy.
  exp_t q[$];
  exp_t cur;
  obs_t obs, expv;

  function automatic exp_t idle_rec();
    exp_t r;
    r     = '0;
    r.sel = NOP;
    return r;
  endfunction

  task automatic model_edge();
    exp_t       r;
    logic [5:0] f;
    if (abort) begin
      q.delete();
      cur = idle_rec();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (!cur.busy && op_bus.op_valid) begin
      f = op_bus.op_funct;
      r = idle_rec();
      if (f inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0}) begin
        r.busy = 1'b1; r.sel = f; r.rv = 1'b1;
        q.push_back(r);
      end else if (f == 6'd25) begin
        for (int i = 0; i < WIDTH; i++) begin
          r = idle_rec();
          r.busy = 1'b1; r.sel = 6'd25; r.step = 1'b1;
          r.start = (i == 0); r.cnt = 6'(i);
          q.push_back(r);
        end
        r = idle_rec();
        r.busy = 1'b1; r.sel = 6'd63; r.hilo = 1'b1; r.rv = 1'b1;
        q.push_back(r);
      end else begin
        r.ill = 1'b1;
        q.push_back(r);
      end
      cur = q.pop_front();
    end else begin
      cur = idle_rec();
    end
  endtask

  task automatic cyc(input logic v, input logic [5:0] f, input logic a);
    op_bus.op_valid = v;
    op_bus.op_funct = f;
    abort           = a;
    @(negedge clk);
    obs  = {op_bus.op_ready, busy, alu_sel, mul_start, mul_step, mul_count,
            hilo_we, res_valid, illegal};
    expv = {!cur.busy && !abort, cur};
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    op_bus.op_valid = 1'b0;
    op_bus.op_funct = 6'd0;
    abort = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (op_bus.op_ready !== 1'b1 || alu_sel !== NOP ||
        {busy, mul_start, mul_step, mul_count, hilo_we, res_valid, illegal} !== 12'h000) begin
      errors++;
      $display("FAIL reset_values: ready=%b sel=%0d busy=%b start=%b step=%b cnt=%0d hilo=%b rv=%b ill=%b, required ready=1 sel=%0d rest 0",
               op_bus.op_ready, alu_sel, busy, mul_start, mul_step, mul_count, hilo_we, res_valid, illegal, NOP);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    cur = idle_rec();
  endtask

  task automatic test_add();
    cyc(1'b1, 6'd32, 1'b0);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL add_accept: got %h required %h", obs, expv); end
    cyc(1'b0, 6'd0, 1'b0);
    checks++;
    if (obs !== expv || obs.e.sel !== 6'd32 || obs.e.rv !== 1'b1 || obs.rdy !== 1'b0) begin
      errors++; $display("FAIL add_exec: got %h required %h (sel 32, rv 1, ready 0)", obs, expv);
    end
    cyc(1'b0, 6'd0, 1'b0);
    checks++;
    if (obs !== expv || obs.rdy !== 1'b1 || obs.e.busy !== 1'b0) begin
      errors++; $display("FAIL add_idle: got %h required %h", obs, expv);
    end
  endtask

  task automatic test_multu();
    int steps = 0, starts = 0, start_at = -1, hilo_at = -1;
    cyc(1'b1, 6'd25, 1'b0);
    for (int k = 1; k <= WIDTH + 2; k++) begin
      cyc(1'b0, 6'($urandom), 1'b0);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL multu_cycle%0d: got %h required %h", k, obs, expv); end
      if (obs.e.step) steps++;
      if (obs.e.start) begin starts++; start_at = k; end
      if (obs.e.hilo) begin
        hilo_at = k;
        checks++;
        if (obs.e.sel !== 6'd63 || obs.e.rv !== 1'b1) begin
          errors++; $display("FAIL multu_hilo_sel: sel=%0d rv=%b required sel=63 rv=1", obs.e.sel, obs.e.rv);
        end
      end
    end
    checks++;
    if (steps != WIDTH || starts != 1 || start_at != 1 || hilo_at != WIDTH + 1) begin
      errors++;
      $display("FAIL multu_timing: steps=%0d starts=%0d start_at=%0d hilo_at=%0d required %0d,1,1,%0d",
               steps, starts, start_at, hilo_at, WIDTH, WIDTH + 1);
    end
  endtask

  task automatic test_illegal();
    cyc(1'b1, 6'b000111, 1'b0);
    cyc(1'b0, 6'd0, 1'b0);
    checks++;
    if (obs !== expv || obs.e.ill !== 1'b1 || obs.e.busy !== 1'b0 || obs.e.rv !== 1'b0) begin
      errors++; $display("FAIL illegal_pulse: got %h required %h", obs, expv);
    end
    cyc(1'b0, 6'd0, 1'b0);
    checks++;
    if (obs !== expv || obs.e.ill !== 1'b0) begin
      errors++; $display("FAIL illegal_clear: got %h required %h", obs, expv);
    end
  endtask

  task automatic test_abort_mul();
    int hilo_seen = 0;
    cyc(1'b1, 6'd25, 1'b0);
    for (int k = 1; k <= 10; k++) cyc(1'b0, 6'd0, 1'b0);
    cyc(1'b1, 6'd32, 1'b1);
    checks++;
    if (obs !== expv || obs.e.cnt !== 6'd10 || obs.rdy !== 1'b0) begin
      errors++; $display("FAIL abort_at10: got %h required %h", obs, expv);
    end
    cyc(1'b0, 6'd0, 1'b0);
    checks++;
    if (obs !== expv || obs.e.busy !== 1'b0 || obs.e.cnt !== 6'd0) begin
      errors++; $display("FAIL abort_idle: got %h required %h", obs, expv);
    end
    for (int k = 0; k < WIDTH + 4; k++) begin
      cyc(1'b0, 6'd0, 1'b0);
      if (obs.e.hilo) hilo_seen++;
    end
    checks++;
    if (hilo_seen != 0) begin errors++; $display("FAIL abort_no_hilo: hilo cycles=%0d required 0", hilo_seen); end
    test_add();
  endtask

  task automatic test_abort_hilo();
    cyc(1'b1, 6'd25, 1'b0);
    for (int k = 1; k <= WIDTH; k++) cyc(1'b0, 6'd0, 1'b0);
    cyc(1'b0, 6'd0, 1'b1);
    checks++;
    if (obs !== expv || obs.e.hilo !== 1'b1) begin
      errors++; $display("FAIL abort_in_hilo: got %h required %h (hilo 1)", obs, expv);
    end
    cyc(1'b0, 6'd0, 1'b0);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL abort_hilo_after: got %h required %h", obs, expv); end
  endtask

  task automatic test_reset_mid_mul();
    cyc(1'b1, 6'd25, 1'b0);
    for (int k = 1; k <= 20; k++) cyc(1'b0, 6'd0, 1'b0);
    #2;
    checks++;
    if (mul_count !== 6'd20) begin errors++; $display("FAIL rst_mid_pre: cnt=%0d required 20", mul_count); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (op_bus.op_ready !== 1'b1 || alu_sel !== NOP ||
        {busy, mul_start, mul_step, mul_count, hilo_we, res_valid, illegal} !== 12'h000) begin
      errors++;
      $display("FAIL rst_mid_async: ready=%b sel=%0d busy=%b step=%b cnt=%0d hilo=%b rv=%b",
               op_bus.op_ready, alu_sel, busy, mul_step, mul_count, hilo_we, res_valid);
    end
    q.delete();
    cur = idle_rec();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_multu();
  endtask

  task automatic test_back_to_back();
    logic [5:0] f;
    for (int j = 0; j < 16; j++) begin
      f = ((j / 2) % 2 == 0) ? 6'd34 : 6'd0;
      cyc(1'b1, f, 1'b0);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL b2b_model%0d: got %h required %h", j, obs, expv); end
      checks++;
      if (j % 2 == 0) begin
        if (obs.rdy !== 1'b1 || obs.e.rv !== 1'b0) begin
          errors++; $display("FAIL b2b_idle%0d: ready=%b rv=%b required 1,0", j, obs.rdy, obs.e.rv);
        end
      end else if (obs.e.rv !== 1'b1 || obs.e.sel !== f) begin
        errors++; $display("FAIL b2b_exec%0d: rv=%b sel=%0d required 1,%0d", j, obs.e.rv, obs.e.sel, f);
      end
    end
    cyc(1'b0, 6'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0] f;
    logic       v, a;
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 9))
        0: f = 6'd36;
        1: f = 6'd37;
        2: f = 6'd32;
        3: f = 6'd34;
        4: f = 6'd42;
        5: f = 6'd0;
        6: f = 6'd25;
        default: f = 6'($urandom_range(0, 63));
      endcase
      v = ($urandom_range(0, 2) != 0);
      a = ($urandom_range(0, 11) == 0);
      cyc(v, f, a);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL random%0d: got %h required %h", n, obs, expv); end
    end
  endtask

  initial begin
    op_bus.op_valid = 1'b0;
    op_bus.op_funct = 6'd0;
    cur = idle_rec();
    test_reset();
    test_add();
    test_multu();
    test_illegal();
    test_abort_mul();
    test_abort_hilo();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
